// File: rtl/add_rr_pipe_if.sv
// rtl/add_rr_pipe_if.sv - operand-read and result-write FIFO bank interfaces
//
// read_interface  : one FWFT FIFO per flux behind a shared tagged data bus.
//    dout  [WIDTH]  data of the flux being read (tag in the upper bits)
//    empty [FLUX]   per-flux empty
//    read  [FLUX]   per-flux pop strobe, taken at the rising clock edge
// write_interface : one FIFO per flux behind a shared tagged data bus.
//    din   [WIDTH]  {tag, data}; the tag selects the destination FIFO
//    write [1]      push strobe
//    full  [FLUX]   per-flux full

interface read_interface #(
   parameter int FLUX  = 2,
   parameter int WIDTH = 28
);
   logic [WIDTH-1:0] dout;
   logic [FLUX-1:0]  empty;
   logic [FLUX-1:0]  read;

   modport actor (input dout, input empty, output read);
   modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
   parameter int FLUX  = 2,
   parameter int WIDTH = 28
);
   logic [WIDTH-1:0] din;
   logic             write;
   logic [FLUX-1:0]  full;

   modport actor (output din, output write, input full);
   modport fifo  (input din, input write, output full);
endinterface

// File: rtl/add_rr_pipe.sv
// rtl/add_rr_pipe.sv - pipelined round-robin multi-flux signed adder actor
//
// Pops one operand pair per cycle from the flux chosen by a round-robin
// arbiter, adds the two signed operands and registers {flux, sum} into the
// result FIFO bank one cycle later. Each flux has a sticky overflow flag.
//
// Optional build macro ADD_SATURATE_EN: overflowing sums clamp to the most
// positive / most negative value instead of wrapping.
//
// Ports:
//    clk            system clock, all state on the rising edge
//    rst_n          synchronous active-low reset
//    read_port_opA  operand A bank (dout, empty[FLUX], read[FLUX])
//    read_port_opB  operand B bank (dout, empty[FLUX], read[FLUX])
//    write_port_sum result bank (din, write, full[FLUX])
//    ovf            sticky per-flux signed-overflow flag

module add_rr_pipe #(
   parameter int FLUX       = 2,
   parameter int DATA_WIDTH = 27,
   parameter int TAG_WIDTH  = $clog2(FLUX)
) (
   input  logic            clk,
   input  logic            rst_n,
   read_interface.actor    read_port_opA,
   read_interface.actor    read_port_opB,
   write_interface.actor   write_port_sum,
   output logic [FLUX-1:0] ovf
);
   localparam int MSB = DATA_WIDTH - 1;

   logic                  out_valid;
   logic [TAG_WIDTH-1:0]  out_tag;
   logic [DATA_WIDTH-1:0] out_data;
   logic [TAG_WIDTH-1:0]  rr_ptr;

   logic [FLUX-1:0]       eligible;
   logic                  gnt_valid;
   logic [TAG_WIDTH-1:0]  gnt_idx;
   logic [TAG_WIDTH-1:0]  rr_next;
   logic [FLUX-1:0]       gnt_onehot;

   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [DATA_WIDTH-1:0] sum_wrap;
   logic [DATA_WIDTH-1:0] sum_res;
   logic                  sum_ovf;
   logic                  unused_tags;

   // The flux whose result sits in the output register is held off for one
   // cycle: its full flag was checked before that write lands, so the slot
   // the write consumes has to be reserved.
   always_comb begin
      for (int i = 0; i < FLUX; i++) begin
         eligible[i] = !read_port_opA.empty[i] && !read_port_opB.empty[i] &&
                       !write_port_sum.full[i] &&
                       !(out_valid && (int'(out_tag) == i));
      end
   end

   // First eligible flux searching upward from rr_ptr, wrapping at FLUX.
   always_comb begin : arbiter
      int idx;
      idx       = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < FLUX; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= FLUX) begin
            idx = idx - FLUX;
         end
         if (!gnt_valid && eligible[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = TAG_WIDTH'(idx);
         end
      end
   end

   assign rr_next = (int'(gnt_idx) == FLUX - 1) ? '0 : gnt_idx + TAG_WIDTH'(1);

   // Reads are killed during reset so no operand is popped into a stage
   // that is being cleared.
   always_comb begin
      gnt_onehot = '0;
      if (rst_n && gnt_valid) begin
         gnt_onehot[gnt_idx] = 1'b1;
      end
   end

   assign read_port_opA.read = gnt_onehot;
   assign read_port_opB.read = gnt_onehot;

   // Operand tag fields are not used: the granted index is the output tag.
   assign op_a        = read_port_opA.dout[DATA_WIDTH-1:0];
   assign op_b        = read_port_opB.dout[DATA_WIDTH-1:0];
   assign unused_tags = ^{read_port_opA.dout[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH],
                          read_port_opB.dout[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH]};

   assign sum_wrap = op_a + op_b;
   assign sum_ovf  = (op_a[MSB] == op_b[MSB]) && (sum_wrap[MSB] != op_a[MSB]);

`ifdef ADD_SATURATE_EN
   always_comb begin
      sum_res = sum_wrap;
      if (sum_ovf) begin
         sum_res = op_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end
   end
`else
   assign sum_res = sum_wrap;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_tag   <= '0;
         out_data  <= '0;
         rr_ptr    <= '0;
         ovf       <= '0;
      end else begin
         out_valid <= gnt_valid;
         if (gnt_valid) begin
            out_tag  <= gnt_idx;
            out_data <= sum_res;
            rr_ptr   <= rr_next;
            if (sum_ovf) begin
               ovf[gnt_idx] <= 1'b1;
            end
         end
      end
   end

   // A result still in the output register while reset is sampled is
   // dropped rather than pushed into the result bank.
   assign write_port_sum.write = out_valid && rst_n;
   assign write_port_sum.din   = {out_tag, out_data};

endmodule

// File: tb/tb_add_rr_pipe.sv
// tb/tb_add_rr_pipe.sv - self-checking bench for add_rr_pipe (FLUX=4, DATA_WIDTH=27)

module tb_add_rr_pipe;
   localparam int F     = 4;
   localparam int DW    = 27;
   localparam int TW    = 2;
   localparam int W     = DW + TW;
   localparam int DEPTH = 64;
   localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (DW - 1));

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [F-1:0]  full_r = '0;
   logic [F-1:0]  ovf_o;
   logic [W-1:0]  dout_a, dout_b;
   logic [F-1:0]  empty_a, empty_b;

   logic [DW-1:0] a_mem [F][DEPTH];
   logic [DW-1:0] b_mem [F][DEPTH];
   int a_wr [F];
   int b_wr [F];
   int a_rd [F];
   int b_rd [F];
   int m_ra [F];
   int m_rb [F];

   int n_cmp = 0;
   int n_err = 0;

   read_interface  #(.FLUX(F), .WIDTH(W)) opa_if ();
   read_interface  #(.FLUX(F), .WIDTH(W)) opb_if ();
   write_interface #(.FLUX(F), .WIDTH(W)) sum_if ();

   add_rr_pipe #(.FLUX(F), .DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .read_port_opA  (opa_if),
      .read_port_opB  (opb_if),
      .write_port_sum (sum_if),
      .ovf            (ovf_o)
   );

   always #5 clk = ~clk;

   // Operand banks: FWFT FIFOs, shared bus shows the flux being read,
   // tag field deliberately filled with a non-matching value.
   always_comb begin
      dout_a = '0;
      dout_b = '0;
      for (int i = 0; i < F; i++) begin
         empty_a[i] = (a_rd[i] == a_wr[i]);
         empty_b[i] = (b_rd[i] == b_wr[i]);
         if (opa_if.read[i]) dout_a = {TW'(F - 1 - i), a_mem[i][a_rd[i] % DEPTH]};
         if (opb_if.read[i]) dout_b = {TW'(F - 1 - i), b_mem[i][b_rd[i] % DEPTH]};
      end
   end

   assign opa_if.dout  = dout_a;
   assign opa_if.empty = empty_a;
   assign opb_if.dout  = dout_b;
   assign opb_if.empty = empty_b;
   assign sum_if.full  = full_r;

   always @(posedge clk) begin
      for (int i = 0; i < F; i++) begin
         if (opa_if.read[i]) a_rd[i] <= a_rd[i] + 1;
         if (opb_if.read[i]) b_rd[i] <= b_rd[i] + 1;
      end
   end

   function automatic longint wide_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return longint'($signed(a)) + longint'($signed(b));
   endfunction

   function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint s;
      logic [63:0] t;
      s = wide_sum(a, b);
`ifdef ADD_SATURATE_EN
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
`endif
      t = s;
      return t[DW-1:0];
   endfunction

   function automatic logic model_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint s;
      s = wide_sum(a, b);
      return (s > MAXV) || (s < MINV);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int f, input logic [DW-1:0] a, input logic [DW-1:0] b);
      a_mem[f][a_wr[f] % DEPTH] = a;
      b_mem[f][b_wr[f] % DEPTH] = b;
      a_wr[f]++;
      b_wr[f]++;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      full_r = '0;
      for (int i = 0; i < F; i++) begin
         a_wr[i] = a_rd[i];
         b_wr[i] = b_rd[i];
         m_ra[i] = a_rd[i];
         m_rb[i] = b_rd[i];
      end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      full_r = '0;
      for (int i = 0; i < F; i++) push(i, DW'(i + 1), DW'(10 * i));
      tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (opa_if.read !== 4'b0000 || opb_if.read !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_read c%0d: got %b/%b want 0000", c, opa_if.read, opb_if.read);
         end
         n_cmp++;
         if (sum_if.write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_write c%0d: got %b want 0", c, sum_if.write);
         end
         n_cmp++;
         if (ovf_o !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ovf c%0d: got %b want 0000", c, ovf_o);
         end
         tick();
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (opa_if.read !== 4'b0001 || opb_if.read !== 4'b0001) begin
         n_err++;
         $display("FAIL reset_first_grant: got %b/%b want 0001", opa_if.read, opb_if.read);
      end
      tick();
   endtask

   task automatic test_fairness();
      logic [DW-1:0] va [F][2];
      logic [DW-1:0] vb [F][2];
      logic [F-1:0]  e;
      logic [W-1:0]  ed;
      do_reset();
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < F; i++) begin
            va[i][p] = DW'($urandom);
            vb[i][p] = DW'($urandom);
            push(i, va[i][p], vb[i][p]);
         end
      end
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         e = '0;
         if (k < 8) e[k % F] = 1'b1;
         n_cmp++;
         if (opa_if.read !== e || opb_if.read !== e) begin
            n_err++;
            $display("FAIL fair_grant k%0d: got %b/%b want %b", k, opa_if.read, opb_if.read, e);
         end
         n_cmp++;
         if (sum_if.write !== (k > 0)) begin
            n_err++;
            $display("FAIL fair_write k%0d: got %b want %b", k, sum_if.write, (k > 0));
         end
         if (k > 0) begin
            ed = {TW'((k - 1) % F), model_sum(va[(k - 1) % F][(k - 1) / F], vb[(k - 1) % F][(k - 1) / F])};
            n_cmp++;
            if (sum_if.din !== ed) begin
               n_err++;
               $display("FAIL fair_din k%0d: got %h want %h", k, sum_if.din, ed);
            end
         end
         tick();
      end
   endtask

   task automatic test_single_flux();
      logic [F-1:0] e;
      logic [W-1:0] ed;
      do_reset();
      for (int p = 0; p < 4; p++) push(1, DW'(5), DW'(-7));
      ed = {2'd1, DW'(-2)};
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         e = (k % 2 == 0 && k < 8) ? 4'b0010 : 4'b0000;
         n_cmp++;
         if (opa_if.read !== e || opb_if.read !== e) begin
            n_err++;
            $display("FAIL single_read k%0d: got %b/%b want %b", k, opa_if.read, opb_if.read, e);
         end
         n_cmp++;
         if (sum_if.write !== (k % 2 == 1)) begin
            n_err++;
            $display("FAIL single_write k%0d: got %b want %b", k, sum_if.write, (k % 2 == 1));
         end
         if (k % 2 == 1) begin
            n_cmp++;
            if (sum_if.din !== ed) begin
               n_err++;
               $display("FAIL single_din k%0d: got %h want %h", k, sum_if.din, ed);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [F-1:0] e;
      logic         seen;
      do_reset();
      full_r = 4'b0001;
      for (int p = 0; p < 3; p++) begin
         push(0, DW'(p), DW'(1));
         push(1, DW'(p), DW'(2));
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         e = (k % 2 == 0) ? 4'b0010 : 4'b0000;
         n_cmp++;
         if (opa_if.read !== e || opb_if.read !== e) begin
            n_err++;
            $display("FAIL bp_read k%0d: got %b/%b want %b", k, opa_if.read, opb_if.read, e);
         end
         n_cmp++;
         if (sum_if.write === 1'b1 && sum_if.din[W-1:DW] === 2'd0) begin
            n_err++;
            $display("FAIL bp_write_full k%0d: got write to tag 0 want none", k);
         end
         tick();
      end
      full_r = 4'b0000;
      seen = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (opa_if.read[0] === 1'b1 && opb_if.read[0] === 1'b1) seen = 1'b1;
         tick();
      end
      n_cmp++;
      if (seen !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: got flux0 served=%b want 1 within 2 cycles", seen);
      end
   endtask

   task automatic test_overflow();
      logic [F-1:0]  er [4];
      logic [F-1:0]  eo [4];
      logic          ew [4];
      logic [W-1:0]  ed [4];
      logic [DW-1:0] r0, r1;
`ifdef ADD_SATURATE_EN
      r0 = 27'h3FFFFFF;
      r1 = 27'h4000000;
`else
      r0 = 27'h4000000;
      r1 = 27'h3FFFFFF;
`endif
      er = '{4'b0001, 4'b0100, 4'b0001, 4'b0000};
      eo = '{4'b0000, 4'b0001, 4'b0101, 4'b0101};
      ew = '{1'b0, 1'b1, 1'b1, 1'b1};
      ed = '{'0, {2'd0, r0}, {2'd2, r1}, {2'd0, 27'h7FFFFFE}};
      do_reset();
      push(0, DW'(67108863), DW'(1));
      push(2, 27'h4000000, DW'(-1));
      push(0, DW'(-5), DW'(3));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (opa_if.read !== er[k] || opb_if.read !== er[k]) begin
            n_err++;
            $display("FAIL ovf_read k%0d: got %b/%b want %b", k, opa_if.read, opb_if.read, er[k]);
         end
         n_cmp++;
         if (ovf_o !== eo[k]) begin
            n_err++;
            $display("FAIL ovf_flag k%0d: got %b want %b", k, ovf_o, eo[k]);
         end
         n_cmp++;
         if (sum_if.write !== ew[k]) begin
            n_err++;
            $display("FAIL ovf_write k%0d: got %b want %b", k, sum_if.write, ew[k]);
         end
         if (ew[k]) begin
            n_cmp++;
            if (sum_if.din !== ed[k]) begin
               n_err++;
               $display("FAIL ovf_din k%0d: got %h want %h", k, sum_if.din, ed[k]);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [F-1:0] er [5];
      logic         ew [5];
      logic [W-1:0] ed [5];
      int           a2;
      er = '{4'b0010, 4'b0000, 4'b0001, 4'b0100, 4'b0000};
      ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      ed = '{'0, '0, '0, {2'd0, 27'd33}, {2'd2, 27'd15}};
      do_reset();
      push(1, DW'(100), DW'(23));
      a2 = a_wr[2];
      push(2, DW'(7), DW'(8));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (opa_if.read !== er[k] || opb_if.read !== er[k]) begin
            n_err++;
            $display("FAIL rmid_read k%0d: got %b/%b want %b", k, opa_if.read, opb_if.read, er[k]);
         end
         n_cmp++;
         if (sum_if.write !== ew[k]) begin
            n_err++;
            $display("FAIL rmid_write k%0d: got %b want %b", k, sum_if.write, ew[k]);
         end
         if (ew[k]) begin
            n_cmp++;
            if (sum_if.din !== ed[k]) begin
               n_err++;
               $display("FAIL rmid_din k%0d: got %h want %h", k, sum_if.din, ed[k]);
            end
         end
         tick();
         if (k == 0) begin
            rst_n = 1'b0;
            push(0, DW'(11), DW'(22));
         end else if (k == 1) begin
            rst_n = 1'b1;
            n_cmp++;
            if (a_rd[2] !== a2) begin
               n_err++;
               $display("FAIL rmid_consumed: got rd ptr %0d want %0d", a_rd[2], a2);
            end
         end
      end
   endtask

   task automatic test_random();
      int           rr_m;
      int           prev_g;
      int           g;
      int           idx;
      logic [DW-1:0] prev_sum;
      logic [F-1:0] ovf_m;
      logic [F-1:0] e;
      logic [DW-1:0] a, b;
      do_reset();
      rr_m = 0;
      prev_g = -1;
      prev_sum = '0;
      ovf_m = '0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         g = -1;
         for (int k = 0; k < F; k++) begin
            idx = (rr_m + k) % F;
            if (g < 0 && (a_wr[idx] - m_ra[idx]) > 0 && !full_r[idx] && idx != prev_g) g = idx;
         end
         e = '0;
         if (g >= 0) e[g] = 1'b1;
         n_cmp++;
         if (opa_if.read !== e || opb_if.read !== e) begin
            n_err++;
            $display("FAIL rand_read c%0d: got %b/%b want %b", c, opa_if.read, opb_if.read, e);
         end
         n_cmp++;
         if (sum_if.write !== (prev_g >= 0)) begin
            n_err++;
            $display("FAIL rand_write c%0d: got %b want %b", c, sum_if.write, (prev_g >= 0));
         end
         if (prev_g >= 0) begin
            n_cmp++;
            if (sum_if.din !== {TW'(prev_g), prev_sum}) begin
               n_err++;
               $display("FAIL rand_din c%0d: got %h want %h", c, sum_if.din, {TW'(prev_g), prev_sum});
            end
         end
         n_cmp++;
         if (ovf_o !== ovf_m) begin
            n_err++;
            $display("FAIL rand_ovf c%0d: got %b want %b", c, ovf_o, ovf_m);
         end
         if (g >= 0) begin
            a = a_mem[g][m_ra[g] % DEPTH];
            b = b_mem[g][m_rb[g] % DEPTH];
            prev_sum = model_sum(a, b);
            if (model_ovf(a, b)) ovf_m[g] = 1'b1;
            m_ra[g]++;
            m_rb[g]++;
            rr_m = (g + 1) % F;
         end
         prev_g = g;
         tick();
         for (int i = 0; i < F; i++) begin
            full_r[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1 && (a_wr[i] - m_ra[i]) < 8) push(i, DW'($urandom), DW'($urandom));
         end
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single_flux();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
